kronos_mem_arb: RTL and testbench
=================================

Name: kronos_mem_arb

Overview:
- Arbitrates between the instruction-fetch bus and the load/store data bus.
- Grants one shared single-port memory bus at a time; that bus is Wishbone-style and uses a req/ack handshake.
- Sits between the core's fetch and LSU interfaces and the system memory.
- Data accesses have priority. A burst cap guarantees that fetch, and therefore the IF/ID/EX pipeline, is never starved.

Parameters:
- MAX_DATA_BURST, 4: number of consecutive data grants allowed while instr_req is pending before instruction fetch is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock.
- rstz  in  1  asynchronous active-low reset.
- instr_addr  in  32  fetch address.
- instr_req  in  1  fetch request.
- instr_data  out  32  fetch read data.
- instr_ack  out  1  fetch complete.
- data_addr  in  32  load/store address.
- data_wr_data  in  32  store data.
- data_mask  in  4  byte enables.
- data_wr_en  in  1  1 = store, 0 = load.
- data_req  in  1  data request.
- data_rd_data  out  32  load data.
- data_ack  out  1  data complete.
- mem_addr  out  32  shared bus address.
- mem_wr_data  out  32  shared bus write data.
- mem_mask  out  4  shared bus byte enables.
- mem_wr_en  out  1  shared bus write enable.
- mem_req  out  1  shared bus request.
- mem_rd_data  in  32  shared bus read data.
- mem_ack  in  1  shared bus complete.

Behaviour:
- Reset (async, rstz=0):
  - state=IDLE, streak=0.
  - mem_req=0, instr_ack=0, data_ack=0.
  - mem_addr, mem_wr_data, mem_mask and mem_wr_en are all 0.
- FSM states: IDLE, GNT_INSTR, GNT_DATA. State and streak are registered.
- IDLE decision (evaluated each cycle):
  - Only data_req: go to GNT_DATA.
  - Only instr_req: go to GNT_INSTR.
  - Both: GNT_INSTR if streak==MAX_DATA_BURST, otherwise GNT_DATA.
  - Neither: stay in IDLE.
- Streak update on a transition out of IDLE:
  - Into GNT_DATA with instr_req=1: streak+1, saturating at MAX_DATA_BURST.
  - Into GNT_DATA with instr_req=0: streak=0.
  - Into GNT_INSTR: streak=0.
- Latency: mem_req rises the cycle after the request is sampled in IDLE. Minimum round trip is 2 cycles (IDLE, then grant with same-cycle mem_ack).
- In GNT_x:
  - mem_req=1.
  - mem_* outputs are a combinational mux of the owner's inputs.
  - Instruction grant drives mem_wr_en=0, mem_mask=4'hF, mem_wr_data=0.
- Outside a grant: mem_req=0 and all mem_* outputs are 0.
- Completion: mem_ack=1 in GNT_x drives x_ack=1 in that same cycle (combinational), then the FSM returns to IDLE. One idle bubble is mandatory between grants.
- Read data passthrough:
  - instr_data = mem_rd_data, and data_rd_data = mem_rd_data, regardless of grant.
  - Requesters qualify read data with their own ack.
- Acks:
  - Never assert outside the owner's grant.
  - mem_ack seen in IDLE is ignored.
- Requester rules:
  - Hold req and request fields stable until ack.
  - Deassertion mid-grant is illegal. The arbiter holds the grant until mem_ack and still pulses the ack.
  - req may stay high after ack to request back-to-back access; that access is re-arbitrated in IDLE.
- Non-owner request: stays pending with no ack. No request is lost or duplicated; exactly one ack is produced per granted access.
- Reset mid-grant: immediate return to IDLE with mem_req=0. The in-flight access is abandoned and no ack is produced.

Test Plan:
- Single fetch:
  - Stimulus: instr_req=1, instr_addr=0x100; mem_ack one cycle after mem_req, with mem_rd_data=0x00000013.
  - Required: mem_req rises at cycle+1, mem_addr=0x100, mem_wr_en=0, mem_mask=F; instr_ack for 1 cycle with instr_data=0x13; data_ack stays 0.
- Store:
  - Stimulus: data_req=1, data_wr_en=1, data_addr=0x2004, data_wr_data=0xDEADBEEF, data_mask=4'b0011.
  - Required: mem_* mirror those values; data_ack for 1 cycle on mem_ack; instr_ack stays 0.
- Simultaneous requests, both held continuously, MAX_DATA_BURST=4, mem_ack immediate:
  - Required grant order: D, D, D, D, I, D, D, D, D, I, ...
  - Each grant is separated by one IDLE cycle.
- Priority without starvation:
  - Stimulus: instr_req rises while a data grant is in progress and data_req is then dropped.
  - Required: the next grant is instruction; streak clears to 0.
- Wait states:
  - Stimulus: mem_ack delayed 5 cycles.
  - Required: mem_req and mem_addr stay stable for all 5 cycles; the pending instr_req is not granted until the IDLE that follows data_ack.
- Reset mid-grant:
  - Stimulus: rstz pulled low during GNT_DATA.
  - Required: mem_req=0, data_ack=0 and mem_addr=0 immediately (async). After release, a fresh data_req gets a new grant 1 cycle later.

Source files
------------

// File: rtl/kronos_mem_arb.sv
// Arbiter between instruction fetch and load/store onto one shared req/ack memory bus.
// Data wins by default; a capped data streak lets a waiting fetch through.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no owner; arbitrate pending requests, mem_req low
// GNT_INSTR | fetch owns the bus until mem_ack
// GNT_DATA  | load/store owns the bus until mem_ack
module kronos_mem_arb #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_INSTR = 2'd1,
    GNT_DATA  = 2'd2
  } state_t;

  localparam logic [3:0] L_MAX_BURST = 4'(MAX_DATA_BURST);

  state_t     r_state;
  logic [3:0] r_streak;
  logic       r_mem_req;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state   <= IDLE;
      r_streak  <= '0;
      r_mem_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // streak counts data grants taken while a fetch was waiting
          if (data_req && (!instr_req || r_streak != L_MAX_BURST)) begin
            r_state   <= GNT_DATA;
            r_mem_req <= 1'b1;
            if (!instr_req)
              r_streak <= '0;
            else if (r_streak < L_MAX_BURST)
              r_streak <= r_streak + 4'd1;
          end else if (instr_req) begin
            r_state   <= GNT_INSTR;
            r_mem_req <= 1'b1;
            r_streak  <= '0;
          end
        end
        GNT_INSTR, GNT_DATA: begin
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_mask    = '0;
    mem_wr_en   = 1'b0;
    case (r_state)
      GNT_INSTR: begin
        mem_addr = instr_addr;
        mem_mask = 4'hF;
      end
      GNT_DATA: begin
        mem_addr    = data_addr;
        mem_wr_data = data_wr_data;
        mem_mask    = data_mask;
        mem_wr_en   = data_wr_en;
      end
      default: ;
    endcase
  end

  assign mem_req      = r_mem_req;
  assign instr_ack    = (r_state == GNT_INSTR) && mem_ack;
  assign data_ack     = (r_state == GNT_DATA) && mem_ack;
  assign instr_data   = mem_rd_data;
  assign data_rd_data = mem_rd_data;

endmodule

// File: tb/tb_kronos_mem_arb.sv
// Directed bench for kronos_mem_arb: fetch, store, burst cap, wait states, reset mid-grant.
module tb_kronos_mem_arb;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic [31:0] instr_data;
  logic        instr_ack;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic [31:0] data_rd_data;
  logic        data_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_req;
  logic [31:0] mem_rd_data;
  logic        mem_ack;

  int n_chk = 0;
  int n_bad = 0;

  kronos_mem_arb #(.MAX_DATA_BURST(4)) dut (
    .clk          (clk),
    .rstz         (rstz),
    .instr_addr   (instr_addr),
    .instr_req    (instr_req),
    .instr_data   (instr_data),
    .instr_ack    (instr_ack),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_mask    (data_mask),
    .data_wr_en   (data_wr_en),
    .data_req     (data_req),
    .data_rd_data (data_rd_data),
    .data_ack     (data_ack),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_mask     (mem_mask),
    .mem_wr_en    (mem_wr_en),
    .mem_req      (mem_req),
    .mem_rd_data  (mem_rd_data),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstz = 1'b0;
    instr_addr = '0; instr_req = 1'b0;
    data_addr = '0; data_wr_data = '0; data_mask = '0; data_wr_en = 1'b0; data_req = 1'b0;
    mem_rd_data = '0; mem_ack = 1'b0;
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_instr_ack", 32'(instr_ack), 32'd0);
    chk("rst_data_ack", 32'(data_ack), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wr_data, 32'd0);
    chk("rst_mem_mask", 32'(mem_mask), 32'd0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    rstz = 1'b1;
    tick();

    // mem_ack while idle must not produce an ack
    mem_ack = 1'b1; #1;
    chk("idle_ack_instr", 32'(instr_ack), 32'd0);
    chk("idle_ack_data", 32'(data_ack), 32'd0);
    mem_ack = 1'b0;

    // single fetch
    instr_addr = 32'h100; instr_req = 1'b1; #1;
    chk("fetch_req_not_yet", 32'(mem_req), 32'd0);
    tick();
    chk("fetch_mem_req", 32'(mem_req), 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h100);
    chk("fetch_wr_en", 32'(mem_wr_en), 32'd0);
    chk("fetch_mask", 32'(mem_mask), 32'hF);
    chk("fetch_wdata", mem_wr_data, 32'd0);
    chk("fetch_no_ack_yet", 32'(instr_ack), 32'd0);
    tick();
    mem_ack = 1'b1; mem_rd_data = 32'h13; #1;
    chk("fetch_ack", 32'(instr_ack), 32'd1);
    chk("fetch_data", instr_data, 32'h13);
    chk("fetch_no_data_ack", 32'(data_ack), 32'd0);
    instr_req = 1'b0;
    tick();
    mem_ack = 1'b0; #1;
    chk("fetch_ack_done", 32'(instr_ack), 32'd0);
    chk("fetch_idle_req", 32'(mem_req), 32'd0);
    chk("fetch_idle_addr", mem_addr, 32'd0);

    // store
    data_req = 1'b1; data_wr_en = 1'b1; data_addr = 32'h2004;
    data_wr_data = 32'hDEADBEEF; data_mask = 4'b0011;
    tick();
    chk("st_mem_req", 32'(mem_req), 32'd1);
    chk("st_addr", mem_addr, 32'h2004);
    chk("st_wdata", mem_wr_data, 32'hDEADBEEF);
    chk("st_mask", 32'(mem_mask), 32'h3);
    chk("st_wr_en", 32'(mem_wr_en), 32'd1);
    mem_ack = 1'b1; #1;
    chk("st_ack", 32'(data_ack), 32'd1);
    chk("st_no_instr_ack", 32'(instr_ack), 32'd0);
    data_req = 1'b0;
    tick();
    mem_ack = 1'b0; #1;
    chk("st_ack_done", 32'(data_ack), 32'd0);
    chk("st_idle_req", 32'(mem_req), 32'd0);

    // both held: D D D D I repeating, one bubble between grants
    data_wr_en = 1'b0; data_addr = 32'h3000; data_mask = 4'hF;
    instr_addr = 32'h200;
    data_req = 1'b1; instr_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      mem_ack = 1'b1; #1;
      chk($sformatf("burst%0d_instr_ack", i), 32'(instr_ack), (i % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d_data_ack", i), 32'(data_ack), (i % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("burst%0d_addr", i), mem_addr, (i % 5 == 4) ? 32'h200 : 32'h3000);
      tick();
      mem_ack = 1'b0; #1;
      chk($sformatf("burst%0d_bubble", i), 32'(mem_req), 32'd0);
    end

    // two data grants with fetch waiting, then data drops: fetch wins, streak clears
    tick();
    mem_ack = 1'b1; #1;
    chk("starve_d1_ack", 32'(data_ack), 32'd1);
    tick();
    mem_ack = 1'b0;
    tick();
    chk("starve_streak2", 32'(dut.r_streak), 32'd2);
    mem_ack = 1'b1; #1;
    chk("starve_d2_ack", 32'(data_ack), 32'd1);
    data_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("starve_instr_grant", mem_addr, 32'h200);
    chk("starve_streak0", 32'(dut.r_streak), 32'd0);
    mem_ack = 1'b1; #1;
    chk("starve_instr_ack", 32'(instr_ack), 32'd1);
    instr_req = 1'b0;
    tick();
    mem_ack = 1'b0;

    // wait states with fetch pending
    data_addr = 32'h4008; data_req = 1'b1; instr_req = 1'b1;
    tick();
    for (int w = 0; w < 5; w++) begin
      chk($sformatf("wait%0d_req", w), 32'(mem_req), 32'd1);
      chk($sformatf("wait%0d_addr", w), mem_addr, 32'h4008);
      chk($sformatf("wait%0d_iack", w), 32'(instr_ack), 32'd0);
      tick();
    end
    mem_ack = 1'b1; #1;
    chk("wait_data_ack", 32'(data_ack), 32'd1);
    data_req = 1'b0;
    tick();
    mem_ack = 1'b0; #1;
    chk("wait_idle_req", 32'(mem_req), 32'd0);
    chk("wait_idle_iack", 32'(instr_ack), 32'd0);
    tick();
    chk("wait_instr_addr", mem_addr, 32'h200);
    chk("wait_instr_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; #1;
    chk("wait_instr_ack", 32'(instr_ack), 32'd1);
    instr_req = 1'b0;
    tick();
    mem_ack = 1'b0;

    // reset during a data grant
    data_addr = 32'h5000; data_req = 1'b1;
    tick();
    chk("rstmid_req_before", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    rstz = 1'b0; #1;
    chk("rstmid_req", 32'(mem_req), 32'd0);
    chk("rstmid_ack", 32'(data_ack), 32'd0);
    chk("rstmid_addr", mem_addr, 32'd0);
    mem_ack = 1'b0;
    tick();
    rstz = 1'b1; #1;
    tick();
    chk("rstmid_regrant_req", 32'(mem_req), 32'd1);
    chk("rstmid_regrant_addr", mem_addr, 32'h5000);
    mem_ack = 1'b1; #1;
    chk("rstmid_regrant_ack", 32'(data_ack), 32'd1);
    data_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
